// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents: supervisor state enum, registered-output bundle, lost counter
// width, and small helper functions used by the supervisor top.
package pll_sup_pkg;

    // Width of the lock-loss counter exposed on the lost_cnt port.
    localparam int LOST_CNT_W = 8;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } sup_state_e;

    // Output bundle registered alongside the state so every port is a flop.
    typedef struct packed {
        logic pll_rst;
        logic sys_reset;
        logic ready;
        logic fail;
    } sup_out_t;

    // Output encoding for each state; loaded into the output register on the
    // same edge the state register moves, so outputs never lag the state.
    function automatic sup_out_t state_outputs(input sup_state_e st);
        sup_out_t o;
        o.pll_rst   = (st == ST_RESET_PLL);
        o.sys_reset = (st != ST_RUN);
        o.ready     = (st == ST_RUN);
        o.fail      = (st == ST_FAIL);
        return o;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [LOST_CNT_W-1:0] sat_inc(input logic [LOST_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow, level-type status bits entering core_clk-style domains.
// Latency: 2 clk_i edges from a stable input change to q_o.
// Backpressure: none; samples every cycle.
//
// Ports: clk_i (destination clock), rst_ni (async active-low reset, flops
// clear to 0), d_i (asynchronous input), q_o (synchronized output).
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    // meta_q may go metastable; only sync_q is ever consumed.
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for and qualifies lock, retries, and gates system reset.
// Latency: locked rise to ready = 3 + STABLE_CYCLES refclk edges; lock loss in RUN to sys_reset = 3 edges.
// Backpressure: none; req_reset is a single-cycle request accepted in any state and overrides all other events.
//
// Ports: refclk (free-running reference), rst_n (async active-low reset),
// locked (raw async PLL lock), req_reset (sync re-lock request),
// pll_rst (PLL reset, active high), sys_reset (downstream reset, active high),
// ready (locked and stable), fail (retries exhausted), lost_cnt (saturating
// count of lock losses seen while running).
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_PULSE_CYCLES = 16,
    parameter int LOCK_TIMEOUT     = 50000,
    parameter int STABLE_CYCLES    = 1024,
    parameter int MAX_RETRIES      = 3
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    input  logic                  locked,
    input  logic                  req_reset,
    output logic                  pll_rst,
    output logic                  sys_reset,
    output logic                  ready,
    output logic                  fail,
    output logic [LOST_CNT_W-1:0] lost_cnt
);

    // One timer serves the pulse, timeout and stability phases, so it is
    // sized for the largest of the three; it only ever counts to param-1.
    localparam int TIMER_MAX = max3(RST_PULSE_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int TMR_W     = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
    // Retry counter must be able to hold MAX_RETRIES itself.
    localparam int RET_W     = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [TMR_W-1:0] PULSE_LAST   = TMR_W'(RST_PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [RET_W-1:0] RETRY_LIMIT  = RET_W'(MAX_RETRIES);

    logic                  lock_s;
    sup_state_e            state_q;
    sup_out_t              out_q;
    logic [TMR_W-1:0]      timer_q;
    logic [TMR_W-1:0]      timer_d;
    logic [RET_W-1:0]      retries_q;
    logic [RET_W-1:0]      retries_d;
    logic                  retry_exhausted_d;
    logic [LOST_CNT_W-1:0] lost_cnt_q;
    logic [LOST_CNT_W-1:0] lost_cnt_d;
    // Set by reset; makes the first edge after release behave like a
    // req_reset so a full pulse is timed from that edge.
    logic                  start_q;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk_i  (refclk),
        .rst_ni (rst_n),
        .d_i    (locked),
        .q_o    (lock_s)
    );

    assign timer_d           = timer_q + 1'b1;
    assign retries_d         = retries_q + 1'b1;
    assign retry_exhausted_d = (retries_d >= RETRY_LIMIT);
    assign lost_cnt_d        = sat_inc(lost_cnt_q);

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RESET_PLL;
            out_q      <= state_outputs(ST_RESET_PLL);
            timer_q    <= '0;
            retries_q  <= '0;
            lost_cnt_q <= '0;
            start_q    <= 1'b1;
        end else begin
            start_q <= 1'b0;
            if (start_q || req_reset) begin
                // Restart the pulse every cycle the request is held.
                state_q   <= ST_RESET_PLL;
                out_q     <= state_outputs(ST_RESET_PLL);
                timer_q   <= '0;
                retries_q <= '0;
            end else begin
                case (state_q)
                    ST_RESET_PLL: begin
                        if (timer_q == PULSE_LAST) begin
                            state_q <= ST_WAIT_LOCK;
                            out_q   <= state_outputs(ST_WAIT_LOCK);
                            timer_q <= '0;
                        end else begin
                            timer_q <= timer_d;
                        end
                    end
                    ST_WAIT_LOCK: begin
                        // Lock seen on the final timeout cycle still counts as lock.
                        if (lock_s) begin
                            state_q <= ST_STABILIZE;
                            out_q   <= state_outputs(ST_STABILIZE);
                            timer_q <= '0;
                        end else if (timer_q == TIMEOUT_LAST) begin
                            retries_q <= retries_d;
                            timer_q   <= '0;
                            if (retry_exhausted_d) begin
                                state_q <= ST_FAIL;
                                out_q   <= state_outputs(ST_FAIL);
                            end else begin
                                state_q <= ST_RESET_PLL;
                                out_q   <= state_outputs(ST_RESET_PLL);
                            end
                        end else begin
                            timer_q <= timer_d;
                        end
                    end
                    ST_STABILIZE: begin
                        if (!lock_s) begin
                            retries_q <= retries_d;
                            timer_q   <= '0;
                            if (retry_exhausted_d) begin
                                state_q <= ST_FAIL;
                                out_q   <= state_outputs(ST_FAIL);
                            end else begin
                                state_q <= ST_RESET_PLL;
                                out_q   <= state_outputs(ST_RESET_PLL);
                            end
                        end else if (timer_q == STABLE_LAST) begin
                            state_q   <= ST_RUN;
                            out_q     <= state_outputs(ST_RUN);
                            timer_q   <= '0;
                            retries_q <= '0;
                        end else begin
                            timer_q <= timer_d;
                        end
                    end
                    ST_RUN: begin
                        if (!lock_s) begin
                            state_q    <= ST_RESET_PLL;
                            out_q      <= state_outputs(ST_RESET_PLL);
                            timer_q    <= '0;
                            lost_cnt_q <= lost_cnt_d;
                        end
                    end
                    ST_FAIL: begin
                        // Terminal until req_reset or rst_n.
                        timer_q <= '0;
                    end
                    default: begin
                        state_q <= ST_RESET_PLL;
                        out_q   <= state_outputs(ST_RESET_PLL);
                        timer_q <= '0;
                    end
                endcase
            end
        end
    end

    assign pll_rst   = out_q.pll_rst;
    assign sys_reset = out_q.sys_reset;
    assign ready     = out_q.ready;
    assign fail      = out_q.fail;
    assign lost_cnt  = lost_cnt_q;

endmodule
